spike_rate_decoder: RTL and testbench



---
 rtl/spike_rate_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Receiver for the 1-bit spike line of an integrate-and-fire neuron. It turns
// the spike train into two measurements:
//   * rate: number of spike events in each window of window_len cycles.
//     Windows run back-to-back.
//   * isi:  interval, in cycles, between the two most recent spike events.
// The rate result is offered to downstream readout logic over a valid/ready
// handshake. If a window completes while the previous result is still
// unconsumed, the new result is dropped and the sticky overrun flag is set.
//
// A spike event is a rising edge of spike_in, so a level held high counts
// once.
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   rst         asynchronous active-high reset
//   en          decoder enable; dropping it abandons the current window
//   spike_in    spike line from the neuron (synchronous to clk)
//   window_len  window length in cycles; sampled at each window start.
//               A value of 0 is treated as 1.
//   rate_out    spike count of the last captured window
//   rate_sat    the count in that window hit its ceiling
//   isi_out     last measured inter-spike interval (saturating)
//   out_valid   rate_out/rate_sat hold an unconsumed result
//   out_ready   consumer accepts the result
//   overrun     sticky: a completed window was dropped; cleared on disable
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
  parameter int WINDOW_W = 16,
  parameter int CNT_W    = 8,
  parameter int ISI_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [CNT_W-1:0]    rate_out,
  output logic                rate_sat,
  output logic [ISI_W-1:0]    isi_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

  state_t state, state_next;

  logic                prev_spike;
  logic [WINDOW_W-1:0] wcnt, wcnt_next;
  logic [CNT_W-1:0]    count, count_next;
  logic                sat, sat_next;
  logic [ISI_W-1:0]    timer;
  logic                have_prev;

  logic                spike_event;
  logic [WINDOW_W-1:0] win_reload;
  logic [CNT_W-1:0]    cnt_plus;
  logic                sat_plus;
  logic [ISI_W-1:0]    isi_meas;
  logic                window_end;
  logic                leave_count;
  logic                can_capture;

  assign spike_event = spike_in & ~prev_spike;

  // Reload value is N-1 so that a window covers exactly N edges and ends on
  // the edge where wcnt reads zero.
  assign win_reload = (window_len == '0) ? '0 : window_len - WINDOW_W'(1);

  // Count including this edge's event, holding at the ceiling. The saturation
  // flag records that an event arrived while the count was already full.
  always_comb begin
    cnt_plus = count;
    sat_plus = sat;
    if (spike_event) begin
      if (count == CNT_MAX) begin
        sat_plus = 1'b1;
      end else begin
        cnt_plus = count + CNT_W'(1);
      end
    end
  end

  // Interval ending on this edge: timer counts edges since the last event.
  assign isi_meas = (timer == ISI_MAX) ? ISI_MAX : timer + ISI_W'(1);

  // A captured result may overwrite the held one only if that one is gone or
  // is being consumed on this very edge.
  assign can_capture = ~out_valid | out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and window datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    wcnt_next   = wcnt;
    count_next  = count;
    sat_next    = sat;
    window_end  = 1'b0;
    leave_count = 1'b0;

    unique case (state)
      IDLE: begin
        if (en) begin
          state_next = COUNT;
          wcnt_next  = win_reload;
          count_next = '0;
          sat_next   = 1'b0;
        end
      end

      COUNT: begin
        if (!en) begin
          // Partial window is abandoned; nothing is emitted for it.
          state_next  = IDLE;
          leave_count = 1'b1;
          wcnt_next   = '0;
          count_next  = '0;
          sat_next    = 1'b0;
        end else if (wcnt == '0) begin
          window_end = 1'b1;
          wcnt_next  = win_reload;
          count_next = '0;
          sat_next   = 1'b0;
        end else begin
          wcnt_next  = wcnt - WINDOW_W'(1);
          count_next = cnt_plus;
          sat_next   = sat_plus;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and window counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_spike <= 1'b0;
      wcnt       <= '0;
      count      <= '0;
      sat        <= 1'b0;
    end else begin
      state      <= state_next;
      prev_spike <= spike_in;
      wcnt       <= wcnt_next;
      count      <= count_next;
      sat        <= sat_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Result register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_out  <= '0;
      rate_sat  <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (window_end) begin
        if (can_capture) begin
          rate_out  <= cnt_plus;
          rate_sat  <= sat_plus;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Disable starts a fresh session; a pending result survives it.
      if (leave_count) begin
        overrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-spike interval
  // ---------------------------------------------------------------------------
  // The timer only runs while enabled. The first event of a session has no
  // predecessor, so it only arms have_prev; isi_out keeps its old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      have_prev <= 1'b0;
      isi_out   <= '0;
    end else if (!en) begin
      timer     <= '0;
      have_prev <= 1'b0;
    end else if (spike_event) begin
      if (have_prev) begin
        isi_out <= isi_meas;
      end
      timer     <= '0;
      have_prev <= 1'b1;
    end else if (timer != ISI_MAX) begin
      timer <= timer + ISI_W'(1);
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Directed bench for spike_rate_decoder. Two instances share the stimulus:
//   u_dut   default widths (CNT_W=8, ISI_W=16)
//   u_small narrow widths (CNT_W=3, ISI_W=4) to reach count and ISI ceilings
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so "after edge e" means the values registered on edge e.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        spike_in;
  logic [15:0] window_len;
  logic        out_ready;

  logic [7:0]  rate_out;
  logic        rate_sat;
  logic [15:0] isi_out;
  logic        out_valid;
  logic        overrun;

  logic [2:0]  s_rate_out;
  logic        s_rate_sat;
  logic [3:0]  s_isi_out;
  logic        s_out_valid;
  logic        s_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_W(16), .CNT_W(8), .ISI_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_sat   (rate_sat),
    .isi_out    (isi_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  spike_rate_decoder #(.WINDOW_W(16), .CNT_W(3), .ISI_W(4)) u_small (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (s_rate_out),
    .rate_sat   (s_rate_sat),
    .isi_out    (s_isi_out),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .overrun    (s_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    spike_in   = 1'b0;
    out_ready  = 1'b0;
    window_len = 16'd8;
    repeat (3) tick();

    // Reset values
    check("rst_rate",    rate_out,  0);
    check("rst_sat",     rate_sat,  0);
    check("rst_isi",     isi_out,   0);
    check("rst_valid",   out_valid, 0);
    check("rst_overrun", overrun,   0);

    rst = 1'b0;
    repeat (3) tick();
    check("idle_valid", out_valid, 0);

    // Basic window: len 8, en seen on edge 0, events on edges 3 and 6.
    en = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      spike_in = (e == 3 || e == 6);
      tick();
      if (e == 7) check("basic_valid_early", out_valid, 0);
    end
    check("basic_valid", out_valid, 1);
    check("basic_rate",  rate_out,  2);
    check("basic_isi",   isi_out,   3);
    check("basic_sat",   rate_sat,  0);

    // Level spike: line high across window 9..16 and beyond.
    for (int e = 9; e <= 24; e++) begin
      spike_in  = 1'b1;
      out_ready = 1'b1;
      tick();
      if (e == 9) begin
        check("accept_drop_valid", out_valid, 0);
        check("accept_hold_rate",  rate_out,  2);
      end
      if (e == 16) begin
        check("level_rate1",  rate_out,  1);
        check("level_valid1", out_valid, 1);
      end
      if (e == 17) check("level_accept", out_valid, 0);
      if (e == 24) begin
        check("level_rate0",  rate_out,  0);
        check("level_valid0", out_valid, 1);
      end
    end

    // Disable with a pending result: result stays until consumed.
    en        = 1'b0;
    out_ready = 1'b0;
    spike_in  = 1'b0;
    tick();
    check("dis_pending_valid", out_valid, 1);
    check("dis_isi_hold",      isi_out,   3);
    out_ready = 1'b1;
    tick();
    check("idle_consume", out_valid, 0);

    // Backpressure: len 4, windows 1-4, 5-8, 9-12, 13-16.
    out_ready  = 1'b0;
    window_len = 16'd4;
    en         = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      spike_in  = (e == 2 || e == 6 || e == 10 || e == 13 || e == 15);
      out_ready = (e >= 16);
      tick();
      if (e == 4) begin
        check("bp_valid_w1",   out_valid, 1);
        check("bp_rate_w1",    rate_out,  1);
        check("bp_overrun_w1", overrun,   0);
      end
      if (e == 8) begin
        check("bp_overrun_w2", overrun,  1);
        check("bp_rate_w2",    rate_out, 1);
      end
      if (e == 12) check("bp_rate_w3", rate_out, 1);
      if (e == 16) begin
        check("bp_coincide_rate",    rate_out,  2);
        check("bp_coincide_valid",   out_valid, 1);
        check("bp_overrun_sticky",   overrun,   1);
        check("bp_isi",              isi_out,   2);
      end
      if (e == 17) check("bp_accept_drop", out_valid, 0);
    end

    en       = 1'b0;
    spike_in = 1'b0;
    tick();
    check("dis_overrun_clear", overrun, 0);
    check("dis_isi_hold2",     isi_out, 2);

    // Saturation: len 40, events on odd edges 1..39 (20 events).
    window_len = 16'd40;
    out_ready  = 1'b0;
    en         = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      spike_in = (e % 2 == 1);
      tick();
      if (e == 39) check("sat_valid_early", s_out_valid, 0);
    end
    check("sat_small_rate",  s_rate_out,  7);
    check("sat_small_flag",  s_rate_sat,  1);
    check("sat_small_valid", s_out_valid, 1);
    check("sat_big_rate",    rate_out,    20);
    check("sat_big_flag",    rate_sat,    0);

    // Asynchronous reset mid-window, between clock edges.
    spike_in = 1'b0;
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",      out_valid,  0);
    check("arst_rate",       rate_out,   0);
    check("arst_isi",        isi_out,    0);
    check("arst_small_rate", s_rate_out, 0);
    check("arst_small_sat",  s_rate_sat, 0);
    en = 1'b0;
    #2;
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_valid",   out_valid, 0);
    check("post_rst_rate",    rate_out,  0);
    check("post_rst_overrun", overrun,   0);

    // window_len 0 acts as 1; ISI saturation and re-enable behaviour.
    window_len = 16'd0;
    out_ready  = 1'b1;
    for (int e = 0; e <= 43; e++) begin
      spike_in = (e == 1 || e == 31 || e == 36 || e == 43);
      en       = !(e == 32 || e == 33);
      tick();
      if (e == 1) begin
        check("len0_valid", out_valid, 1);
        check("len0_rate1", rate_out,  1);
      end
      if (e == 2) begin
        check("len0_rate0",  rate_out,  0);
        check("len0_valid2", out_valid, 1);
      end
      if (e == 31) begin
        check("isi_small_sat", s_isi_out, 15);
        check("isi_big_30",    isi_out,   30);
      end
      if (e == 36) begin
        check("isi_first_small", s_isi_out, 15);
        check("isi_first_big",   isi_out,   30);
      end
      if (e == 43) begin
        check("isi_second_small", s_isi_out, 7);
        check("isi_second_big",   isi_out,   7);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
